// File: rtl/elevator_call_panel.sv
// elevator_call_panel
// Debounces four floor buttons, latches pending calls with lamp feedback and
// issues one target floor at a time to the elevator controller in
// direction-preserving (collective) order, waiting for arrival on floor_out_i.
// Optional build macro: CALL_PANEL_TIMEOUT_EN adds a DRIVE watchdog that
// abandons an unreachable target and raises the sticky err_o flag.
module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int DOOR_HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] btn_i,
    input  logic [1:0] floor_out_i,
    output logic [1:0] floor_o,
    output logic       req_valid_o,
    output logic [3:0] btn_led_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int DOOR_W = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_DRIVE  = 2'd2,
        ST_DOOR   = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        floor_q;
    logic              req_valid_q;
    logic              busy_q;
    logic              dir_q;          // 1 = sweeping up, 0 = sweeping down
    logic [DOOR_W-1:0] door_cnt_q;
    logic [3:0]        pending_q;
    logic [3:0]        pending_d;

    logic [3:0]        press_ev;       // one-cycle rising edge of each debounced button
    logic              arrive;
    logic              timeout_hit;
    logic              here_hit;
    logic              door_restart;

    // ------------------------------------------------------------------
    // Button input path: synchronizer + debounce, one instance per floor
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            level_q;
            logic [DB_W-1:0] cnt_q;
            logic            settle;

            // The level flips on the sample that completes the stable run,
            // so the press event lines up with the edge that updates level_q.
            assign settle       = (sync2_q != level_q) && (cnt_q == DB_LAST);
            assign press_ev[gi] = settle && sync2_q;

            // Two-flop synchronizer followed by a stability counter on the synchronized level
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_i[gi];
                    sync2_q <= sync1_q;
                    if (sync2_q == level_q) begin
                        cnt_q <= '0;
                    end else if (settle) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + DB_W'(1);
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Target search relative to the current car position
    // ------------------------------------------------------------------
    logic       up_found;
    logic [1:0] up_idx;
    logic       dn_found;
    logic [1:0] dn_idx;
    logic       sel_found;
    logic [1:0] sel_idx;
    logic       sel_flip;

    // Nearest pending call above (lowest index) and below (highest index) the car
    always_comb begin
        up_found = 1'b0;
        up_idx   = 2'd0;
        dn_found = 1'b0;
        dn_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i] && (2'(i) > floor_out_i)) begin
                up_found = 1'b1;
                up_idx   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i] && (2'(i) < floor_out_i)) begin
                dn_found = 1'b1;
                dn_idx   = 2'(i);
            end
        end
    end

    // Keep the sweep direction while it still has work, otherwise reverse
    // and take the nearest call on the other side in the same cycle.
    always_comb begin
        sel_flip  = dir_q ? !up_found : !dn_found;
        sel_found = up_found || dn_found;
        if (dir_q) begin
            sel_idx = up_found ? up_idx : dn_idx;
        end else begin
            sel_idx = dn_found ? dn_idx : up_idx;
        end
    end

    // ------------------------------------------------------------------
    // Pending-call register
    // ------------------------------------------------------------------
    assign arrive       = (state_q == ST_DRIVE) && (floor_out_i == floor_q);
    assign here_hit     = (state_q == ST_SELECT) && pending_q[floor_out_i];
    assign door_restart = (state_q == ST_DOOR) && press_ev[floor_out_i];

    logic [3:0] set_mask;
    logic [3:0] clr_mask;

    // Merge new presses and service clears; a clear on the same edge wins
    always_comb begin
        set_mask = press_ev;
        // The car is already standing at this floor: no call to remember
        if ((state_q == ST_IDLE) || (state_q == ST_DOOR)) begin
            set_mask[floor_out_i] = 1'b0;
        end
        clr_mask = 4'b0000;
        if (here_hit) begin
            clr_mask[floor_out_i] = 1'b1;
        end
        if (arrive || timeout_hit) begin
            clr_mask[floor_q] = 1'b1;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    // Latch calls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 4'b0000;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional DRIVE watchdog
    // ------------------------------------------------------------------
`ifdef CALL_PANEL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] drv_cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == ST_DRIVE) && !arrive && (drv_cnt_q == TO_LAST);
    assign err_o       = err_q;

    // Count cycles spent in DRIVE; a timeout leaves a sticky error behind
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drv_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == ST_DRIVE) begin
                drv_cnt_q <= drv_cnt_q + TO_W'(1);
            end else begin
                drv_cnt_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog DRIVE waits for arrival indefinitely
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequence IDLE -> SELECT -> DRIVE -> DOOR -> SELECT ...
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            floor_q     <= 2'd0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dir_q       <= 1'b1;
            door_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        state_q <= ST_SELECT;
                        busy_q  <= 1'b1;
                    end
                end

                ST_SELECT: begin
                    if (pending_q[floor_out_i]) begin
                        // Call at the current floor: just open the door
                        state_q    <= ST_DOOR;
                        door_cnt_q <= '0;
                    end else begin
                        if (sel_flip) begin
                            dir_q <= ~dir_q;
                        end
                        if (sel_found) begin
                            floor_q     <= sel_idx;
                            req_valid_q <= 1'b1;
                            state_q     <= ST_DRIVE;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                ST_DRIVE: begin
                    // floor_q is frozen here; new calls wait for the next SELECT
                    if (arrive) begin
                        req_valid_q <= 1'b0;
                        door_cnt_q  <= '0;
                        state_q     <= ST_DOOR;
                    end else if (timeout_hit) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_SELECT;
                    end
                end

                ST_DOOR: begin
                    if (door_restart) begin
                        door_cnt_q <= '0;
                    end else if (door_cnt_q == DOOR_LAST) begin
                        state_q <= ST_SELECT;
                    end else begin
                        door_cnt_q <= door_cnt_q + DOOR_W'(1);
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign floor_o     = floor_q;
    assign req_valid_o = req_valid_q;
    assign btn_led_o   = pending_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel (default parameters).
// Inputs change and outputs are sampled on the falling clock edge; each step
// below is annotated with the rising-edge count it corresponds to.
module tb_elevator_call_panel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [1:0] floor_out;
    logic [1:0] floor;
    logic       req_valid;
    logic [3:0] btn_led;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elevator_call_panel dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_i       (btn),
        .floor_out_i (floor_out),
        .floor_o     (floor),
        .req_valid_o (req_valid),
        .btn_led_o   (btn_led),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        btn       = 4'b0100;
        floor_out = 2'd0;
        #2 rst_n  = 1'b0;

        // ---- reset with floor-2 button held ----
        cyc(3);
        chk("rst_floor", floor, 2'd0);
        chk("rst_req", req_valid, 1'b0);
        chk("rst_led", btn_led, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;                       // edge 1 is the next rising edge
        cyc(5);                             // edge 5
        chk("led_before_debounce", btn_led, 4'b0000);
        cyc(1);                             // edge 6 = 2 + DEBOUNCE_CYCLES
        chk("led_latched", btn_led, 4'b0100);
        chk("busy_idle_at_latch", busy, 1'b0);
        cyc(1);                             // edge 7: SELECT
        chk("busy_select", busy, 1'b1);
        chk("req_in_select", req_valid, 1'b0);
        cyc(1);                             // edge 8: DRIVE
        chk("first_floor", floor, 2'd2);
        chk("first_req", req_valid, 1'b1);
        cyc(4);                             // edge 12
        chk("req_held", req_valid, 1'b1);
        floor_out = 2'd2;
        cyc(1);                             // edge 13: arrival
        chk("arrive_req", req_valid, 1'b0);
        chk("arrive_led", btn_led, 4'b0000);
        chk("arrive_busy", busy, 1'b1);
        btn = 4'b0000;
        cyc(8);                             // edge 21: door done -> SELECT
        chk("door_end_busy", busy, 1'b1);
        cyc(1);                             // edge 22: nothing pending -> IDLE
        chk("back_idle", busy, 1'b0);

        // ---- glitch shorter than the debounce window ----
        cyc(8);
        btn = 4'b0010;
        cyc(3);
        btn = 4'b0000;
        cyc(10);
        chk("glitch_led", btn_led, 4'b0000);
        chk("glitch_busy", busy, 1'b0);

        // ---- collective sweep from floor 0 ----
        floor_out = 2'd0;
        btn = 4'b1010;
        cyc(6);                             // edge 6
        chk("sweep_led", btn_led, 4'b1010);
        btn = 4'b0000;
        cyc(2);                             // edge 8
        chk("sweep_t1_floor", floor, 2'd1);
        chk("sweep_t1_req", req_valid, 1'b1);
        cyc(4);                             // edge 12
        floor_out = 2'd1;
        cyc(1);                             // edge 13: arrive at 1
        chk("sweep_t1_arrive_req", req_valid, 1'b0);
        chk("sweep_t1_arrive_led", btn_led, 4'b1000);
        cyc(8);                             // edge 21: last door edge before SELECT
        chk("sweep_door8_req", req_valid, 1'b0);
        chk("sweep_door8_busy", busy, 1'b1);
        cyc(1);                             // edge 22
        chk("sweep_t2_floor", floor, 2'd3);
        chk("sweep_t2_req", req_valid, 1'b1);
        btn = 4'b0001;                      // call for floor 0 while driving to 3
        cyc(6);                             // edge 28
        chk("mid_call_led", btn_led, 4'b1001);
        chk("no_preempt_floor", floor, 2'd3);
        chk("no_preempt_req", req_valid, 1'b1);
        btn = 4'b0000;
        cyc(1);                             // edge 29
        floor_out = 2'd3;
        cyc(1);                             // edge 30: arrive at 3
        chk("sweep_t2_arrive_req", req_valid, 1'b0);
        chk("sweep_t2_arrive_led", btn_led, 4'b0001);
        cyc(9);                             // edge 39: reversed sweep
        chk("sweep_t3_floor", floor, 2'd0);
        chk("sweep_t3_req", req_valid, 1'b1);
        cyc(1);                             // edge 40
        floor_out = 2'd0;
        cyc(1);                             // edge 41: arrive at 0, DOOR starts
        chk("sweep_t3_arrive_req", req_valid, 1'b0);
        chk("sweep_t3_arrive_led", btn_led, 4'b0000);

        // ---- press current floor during DOOR: ignored, hold restarts ----
        btn = 4'b0001;
        cyc(6);                             // edge 47: press event inside DOOR
        chk("door_press_led", btn_led, 4'b0000);
        btn = 4'b0000;
        cyc(3);                             // edge 50: idle here without the restart
        chk("door_restart_busy", busy, 1'b1);
        cyc(5);                             // edge 55: SELECT
        chk("door_restart_select", busy, 1'b1);
        cyc(1);                             // edge 56: IDLE
        chk("door_restart_idle", busy, 1'b0);
        chk("door_restart_led", btn_led, 4'b0000);

        // ---- unreachable target ----
        btn = 4'b0100;
        cyc(6);                             // edge 6
        chk("to_led", btn_led, 4'b0100);
        btn = 4'b0000;
        cyc(2);                             // edge 8: DRIVE to 2 begins
        chk("to_floor", floor, 2'd2);
        cyc(2);                             // edge 10
        btn = 4'b1000;
        cyc(6);                             // edge 16
        chk("to_second_call", btn_led, 4'b1100);
        btn = 4'b0000;
        cyc(55);                            // edge 71: DRIVE cycle 63
        chk("to_err_before", err, 1'b0);
        chk("to_req_before", req_valid, 1'b1);
        cyc(1);                             // edge 72: DRIVE cycle 64
`ifdef CALL_PANEL_TIMEOUT_EN
        chk("to_err_set", err, 1'b1);
        chk("to_req_drop", req_valid, 1'b0);
        chk("to_led_clear", btn_led, 4'b1000);
        cyc(1);                             // edge 73: next call
        chk("to_next_floor", floor, 2'd3);
        chk("to_next_req", req_valid, 1'b1);
`else
        chk("nto_err", err, 1'b0);
        chk("nto_req", req_valid, 1'b1);
        chk("nto_led", btn_led, 4'b1100);
        cyc(1);
        chk("nto_floor", floor, 2'd2);
        chk("nto_req_late", req_valid, 1'b1);
`endif

        // ---- asynchronous reset mid-operation ----
        rst_n = 1'b0;
        #1;
        chk("midrst_floor", floor, 2'd0);
        chk("midrst_req", req_valid, 1'b0);
        chk("midrst_led", btn_led, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err", err, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_led", btn_led, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
# elevator_call_panel

Hall/car call panel that drives the elevator controller's floor request input. It debounces four floor buttons, latches pending calls with lamp feedback, and schedules them in direction-preserving (collective) order. It issues one target at a time on `floor` and waits until the controller's `floor_out` reports arrival. It is the request-side (initiator) counterpart of the elevator controller and sits between the board push-buttons and that controller.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level change (≥1)
- DOOR_HOLD_CYCLES, 8: cycles spent in DOOR after arrival before the next selection (≥1)
- TIMEOUT_CYCLES, 64: max cycles in DRIVE before abandoning a target (only with timeout macro)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- btn  input  4  raw asynchronous floor buttons, bit i = floor i, active-high
- floor_out  input  2  current floor reported by elevator controller
- floor  output  2  target floor request to elevator controller, registered
- req_valid  output  1  high while a target is being driven (DRIVE state)
- btn_led  output  4  pending-call lamps, bit i = call for floor i latched
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky timeout flag, cleared only by reset

## Operation
- Input path per button: 2-flop synchronizer, then debounce counter. Debounced level updates after DEBOUNCE_CYCLES equal consecutive samples differing from it. Rising edge of debounced level = press event.
- Press for floor i sets pending[i]; btn_led = pending. Exception: press for floor == floor_out while in IDLE or DOOR is not latched. In DOOR it restarts the hold counter.
- dir register: 1 = up, 0 = down; reset value up.
- FSM states: IDLE, SELECT, DRIVE, DOOR. Reset state IDLE.
- IDLE: any pending bit set → SELECT.
- SELECT (one cycle):
  - pending[floor_out] set → clear it, go to DOOR.
  - Otherwise, with dir up, target = lowest pending index > floor_out; with dir down, target = highest pending index < floor_out.
  - If none in dir, flip dir and search the opposite side in the same cycle.
  - If still none → IDLE. Otherwise latch target into `floor` → DRIVE.
- DRIVE: req_valid = 1, floor held stable. When floor_out == floor: clear pending[floor], go to DOOR.
- DOOR: count DOOR_HOLD_CYCLES, then → SELECT.
- Presses for other floors are latched in every state. A newly latched call never preempts the target currently in DRIVE.
- Reset mid-operation (any state) → all outputs to reset values immediately; pending and debounce state cleared.
- Reset values: floor = 0, req_valid = 0, btn_led = 0, busy = 0, err = 0.

## Timing
- Press held stable from cycle 0 → pending/btn_led set at edge 2 + DEBOUNCE_CYCLES.
- From IDLE: SELECT one cycle after pending set; floor and req_valid valid one cycle after SELECT.
- Arrival detected on the first edge where floor_out == floor. req_valid deasserts and btn_led bit clears at that same edge.
- DOOR lasts exactly DOOR_HOLD_CYCLES cycles (plus restarts), then one SELECT cycle.
- A press event and a clear for the same floor on the same edge: the clear wins, and the press is dropped.

## Configuration
- CALL_PANEL_TIMEOUT_EN defined:
  - A DRIVE cycle counter runs.
  - When it reaches TIMEOUT_CYCLES without arrival: set err, clear pending[floor], deassert req_valid, go to SELECT.
- CALL_PANEL_TIMEOUT_EN undefined:
  - No counter; err tied 0.
  - DRIVE waits indefinitely for arrival.

## Test plan
- Reset with btn = 4'b0100 held → all outputs 0; after release and settling, btn_led = 4'b0100 at edge 2 + DEBOUNCE_CYCLES, then floor = 2, req_valid = 1 two cycles later.
- Glitch on btn[1] shorter than DEBOUNCE_CYCLES → btn_led stays 0, busy stays 0.
- floor_out = 0, calls for 3 then 1 latched while idle → served 1 then 3 (up sweep). A call for 0 arriving mid-way is served after 3.
- Model floor_out = target after 5 cycles → req_valid falls and btn_led bit clears on the arrival edge; DOOR then lasts 8 cycles before the next req_valid.
- Press current floor during DOOR → not latched; hold restarts (DOOR exactly 8 cycles after the last press event).
- With CALL_PANEL_TIMEOUT_EN, floor_out never matches → err = 1 at cycle 64 of DRIVE, pending bit cleared, next call served. Without the macro, req_valid stays high and err = 0.
